// File: rtl/ysyx_23060236_btb_updater.sv
// BTB updater at the EXU end of the pipeline.
// Compares each resolved next-PC with the one predicted at fetch. On a
// mismatch it sends a one-cycle redirect to the IFU and queues a BTB write.
// It squashes wrong-path results until the redirect target arrives, and it
// drains the write queue into the arbitrated BTB write port.
module ysyx_23060236_btb_updater #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter int QDEPTH   = 2,
    parameter int CNT_LEN  = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                exu_valid,
    output logic                exu_ready,
    input  logic [ADDR_LEN-1:0] exu_pc,
    input  logic [DATA_LEN-1:0] exu_pred_npc,
    input  logic [DATA_LEN-1:0] exu_actual_npc,
    output logic                redirect_valid,
    output logic [ADDR_LEN-1:0] redirect_pc,
    output logic                btb_wvalid,
    input  logic                btb_wready,
    output logic [ADDR_LEN-1:0] btb_awaddr,
    output logic [DATA_LEN-1:0] btb_wdata,
    output logic [CNT_LEN-1:0]  mispred_cnt,
    output logic [CNT_LEN-1:0]  drop_cnt
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef enum logic {
        NORMAL,
        SQUASH
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_LEN-1:0] target_q;
    logic                accept;
    logic                mispredict;
    logic                at_target;
    logic                evaluate;
    logic                take_mis;

    logic [ADDR_LEN-1:0] q_addr [QDEPTH];
    logic [DATA_LEN-1:0] q_data [QDEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;
    logic [ADDR_LEN-1:0] hold_addr;
    logic [DATA_LEN-1:0] hold_data;
    logic                q_full, q_empty;
    logic                deq, enq, drop;

    // EXU is never back-pressured
    assign exu_ready  = 1'b1;
    assign accept     = exu_valid & exu_ready;
    assign mispredict = (exu_pred_npc != exu_actual_npc);
    assign at_target  = (exu_pc == target_q);

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) state_q <= NORMAL;
        else        state_q <= state_d;
    end

    // FSM next-state: leave SQUASH only on a correct result at the target
    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL: if (accept && mispredict) state_d = SQUASH;
            SQUASH: if (accept && at_target)  state_d = mispredict ? SQUASH : NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    // FSM output decode: which accepted transfers are on the correct path
    always_comb begin
        evaluate = 1'b0;
        case (state_q)
            NORMAL:  evaluate = accept;
            SQUASH:  evaluate = accept & at_target;
            default: evaluate = 1'b0;
        endcase
    end

    assign take_mis = evaluate & mispredict;

    // Redirect pulse and target; redirect_pc is the current squash target
    always_ff @(posedge clock) begin
        if (!reset) begin
            redirect_valid <= 1'b0;
            target_q       <= '0;
        end else begin
            redirect_valid <= take_mis;
            if (take_mis) target_q <= ADDR_LEN'(exu_actual_npc);
        end
    end

    assign redirect_pc = target_q;

    // Queue status and handshake decode
    assign q_empty    = (count == '0);
    assign q_full     = (count == (PTR_W+1)'(QDEPTH));
    assign btb_wvalid = ~q_empty;
    assign deq        = btb_wvalid & btb_wready;
    assign enq        = take_mis & (~q_full | deq);
    assign drop       = take_mis & q_full & ~deq;

    // Queue pointers and occupancy; pointers wrap naturally at QDEPTH
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage, cleared on reset so the head slot reads zero
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_addr[PTR_W'(i)] <= '0;
                q_data[PTR_W'(i)] <= '0;
            end
        end else if (enq) begin
            q_addr[wr_ptr] <= exu_pc;
            q_data[wr_ptr] <= exu_actual_npc;
        end
    end

    // Last drained entry, shown on the write port while the queue is empty
    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_addr <= '0;
            hold_data <= '0;
        end else if (deq) begin
            hold_addr <= q_addr[rd_ptr];
            hold_data <= q_data[rd_ptr];
        end
    end

    assign btb_awaddr = q_empty ? hold_addr : q_addr[rd_ptr];
    assign btb_wdata  = q_empty ? hold_data : q_data[rd_ptr];

    // Performance counters, wrapping modulo 2^CNT_LEN
    always_ff @(posedge clock) begin
        if (!reset) begin
            mispred_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (take_mis) mispred_cnt <= mispred_cnt + CNT_LEN'(1);
            if (drop)     drop_cnt    <= drop_cnt + CNT_LEN'(1);
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_btb_updater.sv
// Bench for the BTB updater: queue-based reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_ysyx_23060236_btb_updater;

    localparam int QD = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exu_valid = 1'b0;
    logic        exu_ready;
    logic [31:0] exu_pc = '0;
    logic [31:0] exu_pred_npc = '0;
    logic [31:0] exu_actual_npc = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        btb_wvalid;
    logic        btb_wready = 1'b0;
    logic [31:0] btb_awaddr;
    logic [31:0] btb_wdata;
    logic [31:0] mispred_cnt;
    logic [31:0] drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    ysyx_23060236_btb_updater #(
        .ADDR_LEN(32),
        .DATA_LEN(32),
        .QDEPTH  (QD),
        .CNT_LEN (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .exu_valid     (exu_valid),
        .exu_ready     (exu_ready),
        .exu_pc        (exu_pc),
        .exu_pred_npc  (exu_pred_npc),
        .exu_actual_npc(exu_actual_npc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .btb_wvalid    (btb_wvalid),
        .btb_wready    (btb_wready),
        .btb_awaddr    (btb_awaddr),
        .btb_wdata     (btb_wdata),
        .mispred_cnt   (mispred_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pending writes as a plain FIFO, squash as a flag
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        m_q[$];
    ent_t        m_pop;
    bit          m_on  = 0;
    bit          m_sq  = 0;
    bit          m_rv  = 0;
    logic [31:0] m_tgt = '0;
    logic [31:0] m_mis = '0;
    logic [31:0] m_drop = '0;
    bit          m_eval, m_bad, m_full, m_deq;

    // Each negedge: compare DUT to model, then advance model over next posedge
    initial begin
        forever begin
            @(negedge clock);
            if (m_on) begin
                chk("exu_ready", exu_ready, 1);
                chk("redirect_valid", redirect_valid, m_rv);
                if (m_rv) chk("redirect_pc", redirect_pc, m_tgt);
                chk("btb_wvalid", btb_wvalid, m_q.size() != 0);
                if (m_q.size() != 0) begin
                    chk("btb_awaddr", btb_awaddr, m_q[0].a);
                    chk("btb_wdata", btb_wdata, m_q[0].d);
                end
                chk("mispred_cnt", mispred_cnt, m_mis);
                chk("drop_cnt", drop_cnt, m_drop);
            end
            if (!reset) begin
                m_q.delete();
                m_sq = 0; m_rv = 0; m_tgt = '0; m_mis = '0; m_drop = '0;
                m_on = 1;
            end else if (m_on) begin
                m_eval = exu_valid && (!m_sq || exu_pc == m_tgt);
                m_bad  = m_eval && (exu_pred_npc != exu_actual_npc);
                m_full = (m_q.size() == QD);
                m_deq  = (m_q.size() != 0) && btb_wready;
                if (m_deq) m_pop = m_q.pop_front();
                m_rv = m_bad;
                if (m_bad) begin
                    m_mis++;
                    m_sq  = 1;
                    m_tgt = exu_actual_npc;
                    if (m_full && !m_deq) m_drop++;
                    else m_q.push_back('{exu_pc, exu_actual_npc});
                end else if (m_eval) begin
                    m_sq = 0;
                end
            end
        end
    end

    // Drive one cycle of inputs, then land #1 after the posedge
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] pred,
                        input logic [31:0] act, input logic wr);
        exu_valid      = v;
        exu_pc         = pc;
        exu_pred_npc   = pred;
        exu_actual_npc = act;
        btb_wready     = wr;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        reset = 1'b1;
        chk("rst redirect_valid", redirect_valid, 0);
        chk("rst btb_wvalid", btb_wvalid, 0);
        chk("rst btb_awaddr", btb_awaddr, 0);
        chk("rst btb_wdata", btb_wdata, 0);
        chk("rst mispred_cnt", mispred_cnt, 0);
        chk("rst drop_cnt", drop_cnt, 0);

        // 1: correct prediction
        step(1, 32'h8000_0000, 32'h8000_0004, 32'h8000_0004, 1);
        chk("t1 redirect", redirect_valid, 0);
        chk("t1 wvalid", btb_wvalid, 0);
        chk("t1 mispred", mispred_cnt, 0);

        // 2: taken mispredict
        step(1, 32'h8000_0010, 32'h8000_0014, 32'h8000_0100, 1);
        chk("t2 redirect", redirect_valid, 1);
        chk("t2 redirect_pc", redirect_pc, 32'h8000_0100);
        chk("t2 wvalid", btb_wvalid, 1);
        chk("t2 awaddr", btb_awaddr, 32'h8000_0010);
        chk("t2 wdata", btb_wdata, 32'h8000_0100);
        chk("t2 mispred", mispred_cnt, 1);

        // 3: wrong-path results squashed, then the target resolves correctly
        step(1, 32'h8000_0014, 32'h8000_0018, 32'h8000_0050, 1);
        chk("t3 redirect once", redirect_valid, 0);
        chk("t3 drained", btb_wvalid, 0);
        step(1, 32'h8000_0018, 32'h8000_001c, 32'h8000_0060, 1);
        chk("t3 squash redirect", redirect_valid, 0);
        chk("t3 squash mispred", mispred_cnt, 1);
        step(1, 32'h8000_0100, 32'h8000_0104, 32'h8000_0104, 1);
        chk("t3 back redirect", redirect_valid, 0);
        chk("t3 back mispred", mispred_cnt, 1);
        chk("t3 model normal", m_sq, 0);

        // 4: three mispredicts into a two-entry queue with the port stalled
        step(1, 32'h8000_0200, 32'h8000_0204, 32'h8000_0300, 0);
        chk("t4 r1", redirect_valid, 1);
        step(1, 32'h8000_0300, 32'h8000_0304, 32'h8000_0400, 0);
        chk("t4 r2", redirect_valid, 1);
        step(1, 32'h8000_0400, 32'h8000_0404, 32'h8000_0500, 0);
        chk("t4 r3", redirect_valid, 1);
        chk("t4 r3 pc", redirect_pc, 32'h8000_0500);
        chk("t4 drop", drop_cnt, 1);
        chk("t4 mispred", mispred_cnt, 4);
        chk("t4 head addr", btb_awaddr, 32'h8000_0200);
        chk("t4 head data", btb_wdata, 32'h8000_0300);
        chk("t4 model depth", m_q.size(), 2);
        step(0, 0, 0, 0, 1);
        chk("t4 second addr", btb_awaddr, 32'h8000_0300);
        chk("t4 second data", btb_wdata, 32'h8000_0400);
        chk("t4 second valid", btb_wvalid, 1);
        step(0, 0, 0, 0, 1);
        chk("t4 empty", btb_wvalid, 0);

        // 5: full queue with simultaneous dequeue
        step(1, 32'h8000_0500, 32'h8000_0504, 32'h8000_0600, 0);
        step(1, 32'h8000_0600, 32'h8000_0604, 32'h8000_0700, 0);
        step(1, 32'h8000_0700, 32'h8000_0704, 32'h8000_0800, 1);
        chk("t5 drop", drop_cnt, 1);
        chk("t5 mispred", mispred_cnt, 7);
        chk("t5 head", btb_awaddr, 32'h8000_0600);
        chk("t5 model depth", m_q.size(), 2);

        // 6: reset while squashing with two queued entries
        reset = 1'b0;
        step(0, 0, 0, 0, 0);
        reset = 1'b1;
        chk("t6 wvalid", btb_wvalid, 0);
        chk("t6 mispred", mispred_cnt, 0);
        chk("t6 drop", drop_cnt, 0);
        chk("t6 redirect", redirect_valid, 0);
        step(1, 32'h8000_0900, 32'h8000_0904, 32'h8000_0a00, 0);
        chk("t6 redirect", redirect_valid, 1);
        chk("t6 redirect_pc", redirect_pc, 32'h8000_0a00);
        chk("t6 awaddr", btb_awaddr, 32'h8000_0900);
        chk("t6 mispred after", mispred_cnt, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("t6 drained", btb_wvalid, 0);

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060236_btb_updater.md
Name: ysyx_23060236_btb_updater

Overview:
- Sits at the EXU end of the BTB. Compares the next-PC predicted at fetch with the resolved next-PC of each executed instruction.
- On mismatch it issues a one-cycle front-end redirect and queues a BTB write (pc -> correct next-PC).
- It squashes wrong-path results until the redirect target arrives.
- It drains queued writes into the BTB write port (btb_wvalid/btb_awaddr/btb_wdata) under a ready handshake, because the port is arbitrated.

Parameters:
- ADDR_LEN, 32, PC/address width.
- DATA_LEN, 32, BTB data (target) width.
- QDEPTH, 2, update-queue entries; power of two, >=2.
- CNT_LEN, 32, performance counter width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on posedge clock)
- exu_valid  in  1  resolved instruction presented this cycle
- exu_ready  out  1  always 1 out of reset; EXU is never stalled
- exu_pc  in  ADDR_LEN  PC of resolved instruction
- exu_pred_npc  in  DATA_LEN  next-PC predicted at fetch (BTB read result carried down pipe)
- exu_actual_npc  in  DATA_LEN  resolved next-PC
- redirect_valid  out  1  one-cycle flush/redirect pulse to IFU
- redirect_pc  out  ADDR_LEN  fetch restart address
- btb_wvalid  out  1  queue head valid
- btb_wready  in  1  BTB write port accepts this cycle
- btb_awaddr  out  ADDR_LEN  head entry PC
- btb_wdata  out  DATA_LEN  head entry target
- mispred_cnt  out  CNT_LEN  accepted mispredictions
- drop_cnt  out  CNT_LEN  updates lost to a full queue

Behaviour:
- Reset values: redirect_valid=0, redirect_pc=0, btb_wvalid=0, btb_awaddr/btb_wdata=0 (head slot cleared), mispred_cnt=0, drop_cnt=0, queue empty, FSM=NORMAL. Reset mid-operation discards all queued writes and any pending squash.
- Accept: an accepted transfer is exu_valid & exu_ready.
  - A mispredict is an accepted transfer with exu_pred_npc != exu_actual_npc, compared over the full DATA_LEN.
  - Not-taken corrections are ordinary writes with wdata = exu_actual_npc (e.g. pc+4). No invalidate path exists.
- FSM NORMAL:
  - Mispredict: enqueue {exu_pc, exu_actual_npc}, increment mispred_cnt, go to SQUASH with target = exu_actual_npc.
  - Next cycle: redirect_valid=1 and redirect_pc=target, for exactly one cycle. Latency from accept edge is 1 cycle.
  - Correct prediction: no action.
- FSM SQUASH:
  - Accepted transfers with exu_pc != target are dropped. They cause no enqueue, no counter change and no redirect.
  - The transfer with exu_pc == target is evaluated as in NORMAL in the same cycle.
    - If it is correct, return to NORMAL.
    - If it mispredicts, enqueue, increment mispred_cnt, stay in SQUASH with the new target, and redirect next cycle.
- Queue: FIFO of QDEPTH entries with pointer wrap at QDEPTH.
  - Head visible combinationally on btb_awaddr/btb_wdata while btb_wvalid=1.
  - Dequeue on btb_wvalid & btb_wready.
  - When btb_wvalid=0, btb_awaddr/btb_wdata hold their last value; consumers must not sample them.
- Full queue:
  - Enqueue while full without a same-cycle dequeue drops the new entry and increments drop_cnt.
  - The redirect and the FSM transition still occur; correctness never depends on the BTB write.
  - Full with simultaneous dequeue accepts the new entry, and occupancy is unchanged.
- Empty queue: enqueue makes btb_wvalid=1 the next cycle. Enqueue and dequeue never happen in the same cycle on an empty queue (no bypass).
- Counters wrap modulo 2^CNT_LEN.
- A redirect pulse may coincide with btb_wvalid. The two are independent.

Test Plan:
1. Correct prediction: exu_pc=0x80000000, pred=actual=0x80000004, valid for 1 cycle -> no redirect, btb_wvalid stays 0, mispred_cnt=0.
2. Taken mispredict: pc=0x80000010, pred=0x80000014, actual=0x80000100, btb_wready=1 -> next cycle redirect_valid=1 with redirect_pc=0x80000100 (1 cycle only) and btb_wvalid=1 with awaddr=0x80000010 and wdata=0x80000100; entry drains that cycle; mispred_cnt=1.
3. Squash: after case 2, present pc=0x80000014 and pc=0x80000018, each mispredicting -> both ignored, no redirect. Then pc=0x80000100 with pred=actual=0x80000104 -> FSM NORMAL, mispred_cnt still 1.
4. Full queue: btb_wready=0, QDEPTH=2, three mispredicts each resolving at its target -> queue holds the first two, drop_cnt=1, three redirect pulses. Then btb_wready=1 -> exactly two writes drain in FIFO order.
5. Full with simultaneous dequeue: queue full, btb_wready=1 on the same cycle a mispredict is accepted -> new entry accepted, drop_cnt unchanged.
6. Reset mid-operation: reset=0 for one cycle while in SQUASH with 2 queued entries -> btb_wvalid=0 and counters=0 next cycle; a following pc mismatching the old target is processed normally.
